// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the teaching CPU: next-PC opcodes, fetch FSM states
// and write-back source selects.
package cpu_defs_pkg;
  localparam logic [2:0] NPC_PLUS4 = 3'b000;
  localparam logic [2:0] NPC_BEQ   = 3'b001;
  localparam logic [2:0] NPC_BNE   = 3'b010;
  localparam logic [2:0] NPC_JAL   = 3'b011;
  localparam logic [2:0] NPC_JALR  = 3'b100;

  typedef enum logic [1:0] {PAUSE = 2'd0, RUN = 2'd1, HALT = 2'd2} fetch_state_e;

  localparam logic [1:0] WDSel_FromALU = 2'd0;
  localparam logic [1:0] WDSel_FromMEM = 2'd1;
  localparam logic [1:0] WDSel_FromPC  = 2'd2;
endpackage

// File: rtl/step_sync_edge.sv
// 2-FF synchronizer plus rising-edge detector for asynchronous board buttons.
module step_sync_edge (
  input  logic clk,
  input  logic rstn,
  input  logic async_i,
  output logic rise_o
);
  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC register, next-PC select, run/pause/step/halt control and
// the commit strobe. Define FETCH_WRAP_EN to loop to RESET_PC past the last word.
module fetch_pc_unit
  import cpu_defs_pkg::*;
#(
  parameter int          IM_AW       = 4,
  parameter int          IM_CODE_NUM = 12,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             tick_i,
  input  logic             run_i,
  input  logic             step_i,
  input  logic [2:0]       npc_op_i,
  input  logic             zero_i,
  input  logic [31:0]      imm_i,
  input  logic [31:0]      rs1_i,
  output logic [31:0]      pc_o,
  output logic [IM_AW-1:0] rom_addr_o,
  output logic [31:0]      pc_plus4_o,
  output logic             commit_o,
  output logic             halted_o,
  output logic             fault_o
);
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, npc, jalr_sum;
  logic         fault_q, fault_d, pend_q, pend_d;
  logic         step_rise, commit, misalign, out_of_range;

  step_sync_edge u_step (
    .clk     (clk),
    .rstn    (rstn),
    .async_i (step_i),
    .rise_o  (step_rise)
  );

  assign pc_plus4_o = pc_q + 32'd4;
  assign jalr_sum   = rs1_i + imm_i;

  always_comb begin
    npc = pc_plus4_o;
    case (npc_op_i)
      NPC_BEQ:  npc = zero_i  ? pc_q + imm_i : pc_plus4_o;
      NPC_BNE:  npc = !zero_i ? pc_q + imm_i : pc_plus4_o;
      NPC_JAL:  npc = pc_q + imm_i;
      NPC_JALR: npc = {jalr_sum[31:1], 1'b0};
      default:  npc = pc_plus4_o;
    endcase
  end

  assign misalign     = |npc[1:0];
  assign out_of_range = npc[31:2] >= 30'(IM_CODE_NUM);
  assign commit = tick_i && ((state_q == RUN) || (state_q == PAUSE && pend_q));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    pend_d  = pend_q;
    case (state_q)
      PAUSE:   if (run_i)  state_d = RUN;
      RUN:     if (!run_i) state_d = PAUSE;
      default: state_d = HALT;
    endcase
    // A boundary hit at commit overrides any run/pause transition.
    if (commit) begin
      if (misalign) begin
        fault_d = 1'b1;
        state_d = HALT;
      end else if (out_of_range) begin
`ifdef FETCH_WRAP_EN
        pc_d    = RESET_PC;
`else
        state_d = HALT;
`endif
      end else begin
        pc_d = npc;
      end
    end
    // Clear wins over a same-cycle edge so steps never queue.
    if (commit)                             pend_d = 1'b0;
    else if (step_rise && state_q != HALT)  pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= PAUSE;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      pend_q  <= pend_d;
    end
  end

  assign pc_o       = pc_q;
  assign rom_addr_o = pc_q[IM_AW+1:2];
  assign commit_o   = commit;
  assign halted_o   = (state_q == HALT);
  assign fault_o    = fault_q;
endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch stage upstream of the instruction ROM and the decode/execute datapath of the single-cycle RISC-V teaching CPU.
- Holds the PC and computes next-PC for sequential, branch, JAL and JALR flow.
- Drives the ROM word address and provides run / pause / single-step / halt control.
- Emits a one-cycle commit strobe that qualifies RF and DM writes, so the whole core runs on the board clock gated by a divider tick instead of a derived clock.

Parameters:
- IM_AW, 4, ROM word-address width.
- IM_CODE_NUM, 12, number of valid instructions; the last valid word index is IM_CODE_NUM-1.
- RESET_PC, 32'h0000_0000, PC value after reset (word aligned).

Ports:
- clk  in  1  board clock.
- rstn  in  1  asynchronous active-low reset.
- tick_i  in  1  one-clk-wide CPU advance pulse from the clock divider.
- run_i  in  1  level: 1 = free run, 0 = pause.
- step_i  in  1  raw single-step button, asynchronous to the core.
- npc_op_i  in  3  next-PC select from Ctrl.
- zero_i  in  1  ALU Zero flag.
- imm_i  in  32  sign-extended immediate from EXT.
- rs1_i  in  32  RD1 from RF, used by JALR.
- pc_o  out  32  current PC.
- rom_addr_o  out  IM_AW  pc_o[IM_AW+1:2].
- pc_plus4_o  out  32  pc_o+4, for the WDSel_FromPC write-back.
- commit_o  out  1  one-clk pulse; PC updates and architectural writes are allowed this cycle.
- halted_o  out  1  core is stopped at end of program or on a fault.
- fault_o  out  1  sticky; a misaligned target was detected.

Behaviour:
Reset (asynchronous, rstn=0):
- pc_o=RESET_PC; commit_o=0; halted_o=0; fault_o=0.
- FSM state is PAUSE; step synchronizer and step_pending are cleared.
- Reset asserted mid-step drops any pending step.

Step input:
- step_i passes through a 2-FF synchronizer followed by rising-edge detection.
- A detected edge sets step_pending.
- step_pending clears when the step's commit fires. Edges arriving while step_pending=1 are ignored; steps do not queue.

FSM states:
- PAUSE:
  - run_i=1 -> RUN.
  - If step_pending=1 and tick_i=1 -> commit one instruction, then stay in PAUSE.
- RUN:
  - Every tick_i=1 -> commit.
  - run_i=0 -> PAUSE, effective the next clk. A tick in the same cycle as the run_i fall still commits.
- HALT:
  - No commits. Only reset exits this state.
  - run_i and step_i are ignored.

Commit rules:
- commit_o=1 for exactly the clk cycle in which the commit condition holds. The condition is combinational on registered state and tick_i.
- pc_o <= npc on that clk edge.

next-PC, npc_op_i (32-bit, wrap-around arithmetic):
- 000: PC+4.
- 001 (BEQ): PC+imm if zero_i=1, else PC+4.
- 010 (BNE): PC+imm if zero_i=0, else PC+4.
- 011 (JAL): PC+imm.
- 100 (JALR): (rs1_i+imm_i) & ~1.
- Other codes are treated as 000.

Boundaries, evaluated at commit:
- npc[1:0] != 0 -> PC holds, fault_o=1, enter HALT.
- npc word index >= IM_CODE_NUM -> PC holds at the last executed instruction, enter HALT. fault_o stays 0 (normal end of program).
- halted_o = (state == HALT).

Optional Feature:
- Macro: FETCH_WRAP_EN.
- Defined: an out-of-range npc is replaced by RESET_PC, no HALT is entered, and the program loops.
- Undefined: halt-at-end behaviour as above.
- The misaligned-target fault halts in both builds.

Decomposition:
- Package cpu_defs_pkg holds:
  - NPC_PLUS4, NPC_BEQ, NPC_BNE, NPC_JAL, NPC_JALR as 3-bit constants.
  - FSM state typedef {PAUSE, RUN, HALT}.
  - The WDSel_* constants.
- Sub-module step_sync_edge: 2-FF synchronizer plus rising-edge detector. It is reused for other board buttons.

Test Plan:
- Reset, then run_i=1 with a tick every 4 clk and npc_op=000. Required: pc_o 0,4,8,… with one commit_o per tick. After the commit at pc=0x2C (IM_CODE_NUM=12), halted_o=1 and pc_o=0x2C. With FETCH_WRAP_EN, pc_o returns to 0x00 instead.
- Pause and pulse step_i three times: pc advances exactly 0 -> 4 -> 8 -> 0xC. A second step edge during pending is dropped, so a double pulse advances PC once.
- pc=0x10, npc_op=001: with zero_i=1, imm=-8, npc=0x08; with zero_i=0, npc=0x14. Repeat with op=010 and the opposite outcomes.
- JALR with rs1=0x21, imm=3: npc=0x24. With rs1=0x22, imm=0: fault_o=1, halted_o=1, pc_o unchanged.
- Assert rstn=0 mid-RUN and while step_pending=1. Required: all outputs return to reset values asynchronously, and no commit occurs after release until a tick with run_i or a new step.
